// File: rtl/bitonic_sort8_seq.sv
// Sequential 8-element bitonic sorter: serial load, one network stage per cycle
// (four compare-swaps), then serial output of the sorted set.
module bitonic_sort8_seq #(
    parameter int DATA_W  = 8,
    parameter bit DESCEND = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [2:0]        stage, stage_nxt;
    logic              load_en, sort_en;

    logic [DATA_W-1:0] data_buf [8];
    logic [DATA_W-1:0] sort_nxt [8];

    logic [3:0]        net_k;
    logic [2:0]        net_j;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
            cnt   <= 3'd0;
            stage <= 3'd0;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
            cnt   <= cnt_nxt;
            stage <= stage_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        stage_nxt = stage;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b0;
        load_en   = 1'b0;
        sort_en   = 1'b0;

        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_en = 1'b1;
                    if (cnt == 3'd7) begin
                        cnt_nxt   = 3'd0;
                        state_nxt = SORT;
                    end else begin
                        cnt_nxt = cnt + 3'd1;
                    end
                end
            end

            SORT: begin
                busy    = 1'b1;
                sort_en = 1'b1;
                if (stage == 3'd5) begin
                    stage_nxt = 3'd0;
                    state_nxt = OUT;
                end else begin
                    stage_nxt = stage + 3'd1;
                end
            end

            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = data_buf[cnt];
                if (out_ready) begin
                    if (cnt == 3'd7) begin
                        cnt_nxt   = 3'd0;
                        state_nxt = LOAD;
                    end else begin
                        cnt_nxt = cnt + 3'd1;
                    end
                end
            end

            default: begin
                state_nxt = LOAD;
                cnt_nxt   = 3'd0;
                stage_nxt = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bitonic network: (k, j) schedule for the current stage
    // ------------------------------------------------------------------
    always_comb begin
        net_k = 4'd2;
        net_j = 3'd1;
        case (stage)
            3'd0: begin net_k = 4'd2; net_j = 3'd1; end
            3'd1: begin net_k = 4'd4; net_j = 3'd2; end
            3'd2: begin net_k = 4'd4; net_j = 3'd1; end
            3'd3: begin net_k = 4'd8; net_j = 3'd4; end
            3'd4: begin net_k = 4'd8; net_j = 3'd2; end
            3'd5: begin net_k = 4'd8; net_j = 3'd1; end
            default: begin net_k = 4'd2; net_j = 3'd1; end
        endcase
    end

    // Pairs within one stage are disjoint, so each swap reads only pre-edge values.
    always_comb begin : compare_swap
        logic [2:0]        ii;
        logic [2:0]        pp;
        logic              asc;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] lo;
        logic [DATA_W-1:0] hi;

        sort_nxt = data_buf;
        ii  = 3'd0;
        pp  = 3'd0;
        asc = 1'b0;
        a   = '0;
        b   = '0;
        lo  = '0;
        hi  = '0;
        for (int i = 0; i < 8; i++) begin
            ii = 3'(i);
            pp = ii ^ net_j;
            if (pp > ii) begin
                asc = (({1'b0, ii} & net_k) == 4'd0) ^ DESCEND;
                a   = data_buf[ii];
                b   = data_buf[pp];
                lo  = (a < b) ? a : b;
                hi  = (a < b) ? b : a;
                sort_nxt[ii] = asc ? lo : hi;
                sort_nxt[pp] = asc ? hi : lo;
            end
        end
    end

    // ------------------------------------------------------------------
    // Element storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the buffer is reset so an aborted pass can never leak old data.
            for (int i = 0; i < 8; i++) begin
                data_buf[i] <= '0;
            end
        end else if (load_en) begin
            data_buf[cnt] <= in_data;
        end else if (sort_en) begin
            data_buf <= sort_nxt;
        end
    end

endmodule

// File: tb/tb_bitonic_sort8_seq.sv
// Bench for bitonic_sort8_seq: an ascending and a descending instance share stimulus
// and are checked against a plain insertion-sort model.
module tb_bitonic_sort8_seq;

    typedef logic [7:0] set_t [8];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, busy_a;
    logic [7:0] out_data_a;
    logic       in_ready_d, out_valid_d, busy_d;
    logic [7:0] out_data_d;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bitonic_sort8_seq #(.DATA_W(8), .DESCEND(1'b0)) dut_asc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready_a),
        .out_valid (out_valid_a),
        .out_data  (out_data_a),
        .out_ready (out_ready),
        .busy      (busy_a)
    );

    bitonic_sort8_seq #(.DATA_W(8), .DESCEND(1'b1)) dut_desc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready_d),
        .out_valid (out_valid_d),
        .out_data  (out_data_d),
        .out_ready (out_ready),
        .busy      (busy_d)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: ascending order by insertion sort.
    function automatic set_t ref_sort(input set_t v);
        set_t r;
        logic [7:0] t;
        r = v;
        for (int i = 1; i < 8; i++) begin
            for (int m = i; m > 0; m--) begin
                if (r[m] < r[m-1]) begin
                    t      = r[m];
                    r[m]   = r[m-1];
                    r[m-1] = t;
                end
            end
        end
        return r;
    endfunction

    // gap_mode: 0 back-to-back, 1 alternating 1010, 2 random
    task automatic load_set(input set_t vals, input int gap_mode);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 200) begin
            @(negedge clk);
            case (gap_mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = vals[idx];
            if (in_valid) begin
                check("load_in_ready", {31'd0, in_ready_a}, 32'd1);
                check("load_busy", {31'd0, busy_a}, 32'd0);
                check("load_out_valid", {31'd0, out_valid_d}, 32'd0);
            end
            if (in_valid && in_ready_a) idx++;
            cyc++;
        end
        check("load_count", idx, 8);
    endtask

    // Returns after the negedge on which out_valid is first seen high.
    task automatic wait_out(input bit hold99);
        int c;
        for (c = 1; c <= 20; c++) begin
            @(negedge clk);
            in_valid = hold99;
            in_data  = 8'd99;
            if (out_valid_a) break;
            check("sort_in_ready", {31'd0, in_ready_a}, 32'd0);
            check("sort_busy", {31'd0, busy_a}, 32'd1);
            check("sort_out_data", {24'd0, out_data_a}, 32'd0);
        end
        check("latency", c - 1, 6);
        check("out_valid_rise", {31'd0, out_valid_a}, 32'd1);
        check("out_valid_rise_d", {31'd0, out_valid_d}, 32'd1);
    endtask

    // ready_mode: 0 tied high, 1 toggled starting low, 2 random
    task automatic drain(input set_t vals, input int ready_mode, input bit hold99);
        set_t       exp;
        int         idx;
        int         cyc;
        bit         prev_stall;
        logic [7:0] prev_a;
        exp        = ref_sort(vals);
        idx        = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_a     = 8'd0;
        while (idx < 8 && cyc < 100) begin
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            check("out_valid", {31'd0, out_valid_a}, 32'd1);
            check("out_asc", {24'd0, out_data_a}, {24'd0, exp[idx]});
            check("out_desc", {24'd0, out_data_d}, {24'd0, exp[7-idx]});
            check("out_in_ready", {31'd0, in_ready_a}, 32'd0);
            if (prev_stall) check("out_stable", {24'd0, out_data_a}, {24'd0, prev_a});
            prev_a     = out_data_a;
            prev_stall = !out_ready;
            if (out_ready && out_valid_a) idx++;
            cyc++;
            @(negedge clk);
            in_valid = hold99;
            in_data  = 8'd99;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("drain_count", idx, 8);
        check("post_in_ready", {31'd0, in_ready_a}, 32'd1);
        check("post_in_ready_d", {31'd0, in_ready_d}, 32'd1);
        check("post_out_valid", {31'd0, out_valid_a}, 32'd0);
        check("post_busy", {31'd0, busy_a}, 32'd0);
        check("post_out_data", {24'd0, out_data_a}, 32'd0);
    endtask

    task automatic run_pass(input set_t vals, input int gap_mode, input int ready_mode,
                            input bit hold99);
        load_set(vals, gap_mode);
        wait_out(hold99);
        drain(vals, ready_mode, hold99);
    endtask

    initial begin : stim
        set_t v;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;

        #2 rst_n = 1'b0;
        #2;
        check("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        check("rst_out_data", {24'd0, out_data_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: reversed input, back-to-back, ready high
        v = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        run_pass(v, 0, 0, 1'b0);

        // 2: duplicates and extremes
        v = '{8'd5, 8'd5, 8'd0, 8'd255, 8'd5, 8'd0, 8'd255, 8'd5};
        run_pass(v, 0, 0, 1'b0);

        // 3: input gaps 1010, output ready toggling
        v = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6};
        run_pass(v, 1, 1, 1'b0);

        // 4: distinct values, exercised on the descending instance too
        v = '{8'd10, 8'd40, 8'd20, 8'd30, 8'd80, 8'd60, 8'd70, 8'd50};
        run_pass(v, 0, 0, 1'b0);

        // 5: reset during SORT stage 3, then a pass of zeros
        v = '{8'd200, 8'd17, 8'd99, 8'd3, 8'd250, 8'd42, 8'd7, 8'd128};
        load_set(v, 0);
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_busy", {31'd0, busy_a}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready_a}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{default: 8'd0};
        run_pass(v, 0, 0, 1'b0);

        // 6: in_valid held high at 99 through SORT and OUT
        v = '{8'd12, 8'd250, 8'd0, 8'd77, 8'd77, 8'd1, 8'd200, 8'd33};
        run_pass(v, 0, 2, 1'b1);
        v = '{8'd99, 8'd4, 8'd98, 8'd100, 8'd5, 8'd6, 8'd255, 8'd0};
        run_pass(v, 0, 0, 1'b0);

        // Randomized passes
        for (int p = 0; p < 8; p++) begin
            for (int e = 0; e < 8; e++) begin
                case ($urandom_range(0, 5))
                    0:       v[e] = 8'd0;
                    1:       v[e] = 8'd255;
                    default: v[e] = 8'($urandom);
                endcase
            end
            run_pass(v, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                     1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
